// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side controller: binary/Gray write pointer, registered full and sticky overflow.
// Optional registered almost-full output is enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int A_WIDTH   = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               winc,
  input  logic [A_WIDTH:0]   wq2_rptr,
  input  logic               wovf_clr,
  output logic               wen,
  output logic [A_WIDTH-1:0] waddr,
  output logic [A_WIDTH:0]   wptr,
  output logic               wfull,
  output logic               wovf
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic               walmost_full
`endif
);

  logic [A_WIDTH:0] wbin;
  logic [A_WIDTH:0] wbin_next;
  logic [A_WIDTH:0] wgray_next;
  logic [A_WIDTH:0] full_ptr;

  // Write handshake: the producer holds winc; a word is taken on any edge where wen=1.
  // wen is gated by reset so the memory never sees a write while the pointers are held at 0.
  assign wen        = winc & ~wfull & wrst_n;
  assign waddr      = wbin[A_WIDTH-1:0];
  assign wbin_next  = wbin + {{A_WIDTH{1'b0}}, wen};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer is exactly one lap ahead of the read pointer (Gray form).
  assign full_ptr = {~wq2_rptr[A_WIDTH:A_WIDTH-1], wq2_rptr[A_WIDTH-2:0]};

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
      wovf  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wptr  <= wgray_next;
      wfull <= (wgray_next == full_ptr);
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [A_WIDTH:0] AF_LEVEL = (A_WIDTH+1)'((2 ** A_WIDTH) - AF_MARGIN);

  logic [A_WIDTH:0] rbin;
  logic [A_WIDTH:0] wlevel;

  always_comb begin
    rbin[A_WIDTH] = wq2_rptr[A_WIDTH];
    for (int i = A_WIDTH - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end
  end

  assign wlevel = wbin_next - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (wlevel >= AF_LEVEL);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with A_WIDTH=3 (depth 8) and AF_MARGIN=2.
// Define FIFO_ALMOST_FULL_EN to also exercise walmost_full.
module tb_fifo_wptr_full;

  localparam int AW = 3;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic          wovf_clr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wovf;
`ifdef FIFO_ALMOST_FULL_EN
  logic          walmost_full;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] gtab [0:8] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'b1100};
  logic [AW:0] prev;

  fifo_wptr_full #(.A_WIDTH(AW), .AF_MARGIN(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .wovf(wovf)
`ifdef FIFO_ALMOST_FULL_EN
    , .walmost_full(walmost_full)
`endif
  );

  // clock
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    wrst_n = 1'b0; winc = 1'b1; wq2_rptr = '0; wovf_clr = 1'b0;
    #1;
    check("rst_wen", wen, 0);
    check("rst_wptr", wptr, 0);
    check("rst_wfull", wfull, 0);
    check("rst_wovf", wovf, 0);
    check("rst_waddr", waddr, 0);
    step();
    winc = 1'b0;
    #2 wrst_n = 1'b1;
    step();

    // fill 8 from empty
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      #1;
      check("fill_wen", wen, 1);
      check("fill_waddr", waddr, i);
      check("fill_wptr_pre", wptr, gtab[i]);
      check("fill_wfull_pre", wfull, 0);
      step();
      check("fill_wptr", wptr, gtab[i+1]);
      check("fill_wfull", wfull, (i == 7));
    end
    check("fill_wovf", wovf, 0);

    // overflow attempts
    #1;
    check("ovf_wen", wen, 0);
    repeat (3) step();
    check("ovf_wptr", wptr, 4'b1100);
    check("ovf_wovf", wovf, 1);
    check("ovf_wfull", wfull, 1);
    wovf_clr = 1'b1;
    step();
    check("ovf_set_prio", wovf, 1);
    winc = 1'b0;
    step();
    check("ovf_clr", wovf, 0);
    wovf_clr = 1'b0;

    // drain one, refill one
    wq2_rptr = 4'b0001;
    step();
    check("drain_wfull", wfull, 0);
    winc = 1'b1;
    #1;
    check("refill_wen", wen, 1);
    check("refill_waddr", waddr, 0);
    step();
    check("refill_wptr", wptr, 4'b1101);
    check("refill_wfull", wfull, 1);
    step();
    check("refill_ovf", wovf, 1);
    check("refill_hold", wptr, 4'b1101);

    // asynchronous reset mid-burst
    #2 wrst_n = 1'b0;
    #1;
    check("arst_wen", wen, 0);
    check("arst_wptr", wptr, 0);
    check("arst_wfull", wfull, 0);
    check("arst_wovf", wovf, 0);
    check("arst_waddr", waddr, 0);
    wq2_rptr = '0;
    step();
    check("arst_hold_wptr", wptr, 0);
    check("arst_hold_wen", wen, 0);
    winc = 1'b0;
    #2 wrst_n = 1'b1;
    step();

    // wrap with read pointer trailing by 3
    winc = 1'b1;
    repeat (3) step();
    check("wrap_start", wptr, 4'd2);
    for (int k = 0; k < 20; k++) begin
      wq2_rptr = gray(4'(k));
      prev = wptr;
      step();
      check("wrap_wptr", wptr, gray(4'(k + 4)));
      check("wrap_wfull", wfull, 0);
      check("wrap_gray1", $countones(prev ^ wptr), 1);
    end
    winc = 1'b0;

`ifdef FIFO_ALMOST_FULL_EN
    #2 wrst_n = 1'b0;
    #2 wrst_n = 1'b1;
    wq2_rptr = '0;
    check("af_rst", walmost_full, 0);
    step();
    for (int i = 1; i <= 6; i++) begin
      winc = 1'b1;
      step();
      check("af_level", walmost_full, (i == 6));
    end
    winc = 1'b0;
    step();
    check("af_hold", walmost_full, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
